// File: rtl/serial_adder_4b.sv
// serial_adder_4b: bit-serial unsigned adder.
// Operands arrive LSB first, one bit per clock on a/b. Each edge produces one
// registered sum bit on out. At the end of every WIDTH-bit word the assembled
// parallel sum, the carry-out and a one-cycle done strobe are also registered.
//
// Framing: there is no valid/ready handshake. Every rising edge with rst low
// consumes one bit pair, and words are delimited purely by the internal bit
// counter. The carry is forced to 0 on the LSB of each word, so words never chain.
module serial_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             cout,
    output logic             done,
    output logic [WIDTH-1:0] sum
);

    localparam int CW = $clog2(WIDTH);

    // Internal state: running carry, bit index within the word, sum shift register
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;

    // Combinational full-adder slice and next-state values
    logic             c_eff;
    logic             s;
    logic             c_next;
    logic             last;
    logic [WIDTH-1:0] acc_next;

    // Full-adder slice with the carry cleared at each word boundary
    always_comb begin
        c_eff    = (cnt == '0) ? 1'b0 : c;
        s        = a ^ b ^ c_eff;
        c_next   = (a & b) | (a & c_eff) | (b & c_eff);
        last     = (cnt == CW'(WIDTH - 1));
        acc_next = {s, acc[WIDTH-1:1]};
    end

    // Bit-serial datapath and end-of-word capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c    <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            out  <= 1'b0;
            cout <= 1'b0;
            done <= 1'b0;
            sum  <= '0;
        end else begin
            out <= s;
            c   <= c_next;
            acc <= acc_next;
            if (last) begin
                cnt  <= '0;
                done <= 1'b1;
                cout <= c_next;
                sum  <= acc_next;
            end else begin
                cnt  <= cnt + CW'(1);
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_4b.sv
// Directed testbench for serial_adder_4b (WIDTH=4).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the following rising edge.
module tb_serial_adder_4b;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       out;
    logic       cout;
    logic       done;
    logic [3:0] sum;

    int errors;
    int checks;

    serial_adder_4b #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .out  (out),
        .cout (cout),
        .done (done),
        .sum  (sum)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Driver: present one bit pair, let one rising edge consume it
    task automatic step(input logic av, input logic bv);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out  !== 1'b0) begin errors++; $display("FAIL reset_por_out: got %0b expected 0", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_por_cout: got %0b expected 0", cout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_por_done: got %0b expected 0", done); end
        checks++; if (sum  !== 4'h0) begin errors++; $display("FAIL reset_por_sum: got %0h expected 0", sum); end
        rst = 1'b0;
        // 7 + 8 = 15 so the outputs are non-zero before the asynchronous reset
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks++; if (sum  !== 4'hf) begin errors++; $display("FAIL pre_reset_sum: got %0h expected f", sum); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pre_reset_done: got %0b expected 1", done); end
        checks++; if (out  !== 1'b1) begin errors++; $display("FAIL pre_reset_out: got %0b expected 1", out); end
        // Assert reset between edges; outputs must clear without a clock edge
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out  !== 1'b0) begin errors++; $display("FAIL reset_async_out: got %0b expected 0", out); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_async_cout: got %0b expected 0", cout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_async_done: got %0b expected 0", done); end
        checks++; if (sum  !== 4'h0) begin errors++; $display("FAIL reset_async_sum: got %0h expected 0", sum); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            checks++; if (out !== 1'b0 || done !== 1'b0 || cout !== 1'b0 || sum !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got out=%0b done=%0b cout=%0b sum=%0h expected all 0", i, out, done, cout, sum);
            end
        end
        a = 1'b0;
        b = 1'b0;
        rst = 1'b0;
    endtask

    // 5 + 3 = 8: a bits 1,0,1,0; b bits 1,1,0,0
    task automatic test_5_plus_3();
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] exp_out;
        av = 4'd5;
        bv = 4'd3;
        exp_out = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step(av[i], bv[i]);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL add53_out[%0d]: got %0b expected %0b", i, out, exp_out[i]); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL add53_done[%0d]: got %0b expected %0b", i, done, (i == 3)); end
        end
        checks++; if (sum  !== 4'b1000) begin errors++; $display("FAIL add53_sum: got %0h expected 8", sum); end
        checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL add53_cout: got %0b expected 0", cout); end
    endtask

    // 15 + 1 = 16: all sum bits 0, carry out 1
    task automatic test_overflow();
        logic [3:0] av;
        logic [3:0] bv;
        av = 4'd15;
        bv = 4'd1;
        for (int i = 0; i < 4; i++) begin
            step(av[i], bv[i]);
            checks++; if (out !== 1'b0) begin errors++; $display("FAIL ovf_out[%0d]: got %0b expected 0", i, out); end
        end
        checks++; if (sum  !== 4'h0) begin errors++; $display("FAIL ovf_sum: got %0h expected 0", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf_cout: got %0b expected 1", cout); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %0b expected 1", done); end
    endtask

    // 15 + 1 immediately followed by 1 + 1: the overflow carry must not leak
    task automatic test_back_to_back();
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] exp_out;
        av = 4'd15;
        bv = 4'd1;
        for (int i = 0; i < 4; i++) step(av[i], bv[i]);
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_first_cout: got %0b expected 1", cout); end
        av = 4'd1;
        bv = 4'd1;
        exp_out = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step(av[i], bv[i]);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %0b expected %0b", i, out, exp_out[i]); end
        end
        checks++; if (sum  !== 4'h2) begin errors++; $display("FAIL b2b_sum: got %0h expected 2", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout: got %0b expected 0", cout); end
    endtask

    // Two bits of 7 + 7, reset, then 2 + 2 framed from the first post-reset edge
    task automatic test_reset_mid_word();
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] exp_out;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst = 1'b1;
        #2;
        checks++; if (sum !== 4'h0 || done !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got sum=%0h done=%0b out=%0b expected 0 0 0", sum, done, out);
        end
        rst = 1'b0;
        av = 4'd2;
        bv = 4'd2;
        exp_out = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(av[i], bv[i]);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL midrst_out[%0d]: got %0b expected %0b", i, out, exp_out[i]); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL midrst_done[%0d]: got %0b expected %0b", i, done, (i == 3)); end
        end
        checks++; if (sum  !== 4'h4) begin errors++; $display("FAIL midrst_sum: got %0h expected 4", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %0b expected 0", cout); end
    endtask

    // All 256 operand pairs streamed with no gaps
    task automatic test_exhaustive();
        logic [3:0] av;
        logic [3:0] bv;
        logic [4:0] exp_total;
        logic [3:0] got_bits;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                av = 4'(x);
                bv = 4'(y);
                exp_total = 5'(x + y);
                got_bits = 4'h0;
                for (int i = 0; i < 4; i++) begin
                    step(av[i], bv[i]);
                    got_bits[i] = out;
                    checks++; if (done !== (i == 3)) begin
                        errors++;
                        $display("FAIL sweep_done %0d+%0d bit%0d: got %0b expected %0b", x, y, i, done, (i == 3));
                    end
                end
                checks++; if ({cout, sum} !== exp_total) begin
                    errors++;
                    $display("FAIL sweep_sum %0d+%0d: got %0d expected %0d", x, y, {cout, sum}, exp_total);
                end
                checks++; if (got_bits !== exp_total[3:0]) begin
                    errors++;
                    $display("FAIL sweep_serial %0d+%0d: got %0h expected %0h", x, y, got_bits, exp_total[3:0]);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a = 1'b0;
        b = 1'b0;
        test_reset();
        test_5_plus_3();
        test_overflow();
        test_back_to_back();
        test_reset_mid_word();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
